// File: rtl/fpf_decoder_25_if.sv
`default_nettype none
// ============================================================================
// Module   : fpf_decoder_25_if
// Purpose  : Bundles the receive-side and consumer-side handshakes of the
//            25-bit FPF codeword decoder.
// Ports    : (interface signals)
//            in_valid  - producer has a codeword on codein
//            in_ready  - decoder accepts codein this cycle
//            codein    - 25-bit FPF codeword, bit k weighted by Fib(k+1)
//            out_valid - dataout/err hold a decoded word
//            out_ready - consumer accepts dataout this cycle
//            dataout   - decoded binary word (FBLEN25 bits)
//            err       - codeword broke FPF rules (0 when checking is absent)
// Modports : master = producer/consumer side, slave = decoder side
// Revision : 1.0 - initial release
// ============================================================================
interface fpf_decoder_25_if;
    // Number of bits needed for the 121393 legal 25-bit FPF values.
    localparam int FBLEN25 = 17;

    logic               in_valid;
    logic               in_ready;
    logic [24:0]        codein;
    logic               out_valid;
    logic               out_ready;
    logic [FBLEN25-1:0] dataout;
    logic               err;

    modport master (
        output in_valid,
        output codein,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dataout,
        input  err
    );

    modport slave (
        input  in_valid,
        input  codein,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dataout,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/fpf_decoder_25.sv
`default_nettype none
// ============================================================================
// Module   : fpf_decoder_25
// Purpose  : Pipelined decoder for 25-bit forbidden-pattern-free codewords.
//            The binary word is the Fibonacci-weighted sum of the codeword
//            bits (bit k weighs Fib(k+1), Fib(1)=Fib(2)=1). Each of STAGES
//            pipeline stages adds 25/STAGES code bits into a running sum.
// Ports    : clock   - rising-edge clock
//            reset_n - synchronous active-low reset
//            bus     - fpf_decoder_25_if.slave (valid/ready in and out)
// Params   : STAGES  - pipeline depth, one of 1, 5, 25
// Config   : FPF_DEC_CHECK_EN - when defined, an error flag travels with
//            each word (forbidden 010/101 triple or sum overflow); when
//            undefined, err is tied to 0 and no check logic exists.
// Revision : 1.0 - initial release
// ============================================================================
module fpf_decoder_25 #(
    parameter int STAGES = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    fpf_decoder_25_if.slave bus
);

    localparam int c_CODE_W = 25;
    localparam int c_FBLEN  = 17;
    localparam int c_ACC_W  = c_FBLEN + 1;
    localparam int c_W      = c_CODE_W / STAGES;
    localparam int c_LAST   = STAGES - 1;

    // Fibonacci weight of code position k (1-based): 1, 1, 2, 3, 5, ...
    function automatic logic [c_ACC_W-1:0] fns(input int k);
        logic [c_ACC_W-1:0] a;
        logic [c_ACC_W-1:0] b;
        logic [c_ACC_W-1:0] t;
        a = 1;
        b = 1;
        for (int i = 2; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    logic                stall;
    logic [STAGES-1:0]   valid_q;
    logic [STAGES-1:0]   valid_d;
    logic [c_ACC_W-1:0]  acc_q  [STAGES];
    logic [c_ACC_W-1:0]  acc_d  [STAGES];
    // Code bits are shifted down as they are consumed, so each stage always
    // reads its share from the low c_W bits of the previous stage.
    logic [c_CODE_W-1:0] code_q [STAGES];
    logic [c_CODE_W-1:0] code_d [STAGES];

`ifdef FPF_DEC_CHECK_EN
    logic [STAGES-1:0]   err_q;
    logic [STAGES-1:0]   err_d;

    function automatic logic has_forbidden(input logic [c_CODE_W-1:0] c);
        logic f;
        f = 1'b0;
        for (int k = 0; k < c_CODE_W - 2; k++) begin
            if (c[k +: 3] == 3'b010 || c[k +: 3] == 3'b101) begin
                f = 1'b1;
            end
        end
        return f;
    endfunction
`endif

    // A word at the output that nobody takes freezes the whole pipe.
    assign stall = valid_q[c_LAST] & ~bus.out_ready;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            logic [c_CODE_W-1:0] code_in;
            logic [c_ACC_W-1:0]  acc_in;
            logic                valid_in;
            logic [c_ACC_W-1:0]  sum;

            if (s == 0) begin : g_head
                assign code_in  = bus.codein;
                assign acc_in   = '0;
                assign valid_in = bus.in_valid;
            end else begin : g_body
                assign code_in  = code_q[s-1];
                assign acc_in   = acc_q[s-1];
                assign valid_in = valid_q[s-1];
            end

            always_comb begin
                sum = acc_in;
                for (int j = 0; j < c_W; j++) begin
                    if (code_in[j]) begin
                        sum = sum + fns(s * c_W + j + 1);
                    end
                end
            end

            assign acc_d[s]   = sum;
            assign code_d[s]  = code_in >> c_W;
            assign valid_d[s] = valid_in;

`ifdef FPF_DEC_CHECK_EN
            // Triples straddle stage boundaries, so the pattern scan is done
            // once on the full codeword at entry; overflow is caught by the
            // spare accumulator bit, which only ever grows along the pipe.
            if (s == 0) begin : g_err_head
                assign err_d[s] = has_forbidden(code_in) | sum[c_FBLEN];
            end else begin : g_err_body
                assign err_d[s] = err_q[s-1] | sum[c_FBLEN];
            end
`endif
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                acc_q[s]  <= '0;
                code_q[s] <= '0;
            end
`ifdef FPF_DEC_CHECK_EN
            err_q <= '0;
`endif
        end else if (!stall) begin
            valid_q <= valid_d;
            for (int s = 0; s < STAGES; s++) begin
                acc_q[s]  <= acc_d[s];
                code_q[s] <= code_d[s];
            end
`ifdef FPF_DEC_CHECK_EN
            err_q <= err_d;
`endif
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = valid_q[c_LAST];
    assign bus.dataout   = acc_q[c_LAST][c_FBLEN-1:0];

`ifdef FPF_DEC_CHECK_EN
    assign bus.err = err_q[c_LAST] & valid_q[c_LAST];
`else
    assign bus.err = 1'b0;
`endif

    // The last stage has no code bits left to pass on and its overflow bit
    // is either discarded or already folded into err.
    logic unused_tail;
    assign unused_tail = ^{code_q[c_LAST], acc_q[c_LAST][c_FBLEN]};

endmodule
`default_nettype wire

// File: tb/tb_fpf_decoder_25.sv
`timescale 1ns/1ps
`default_nettype none
module tb_fpf_decoder_25;

    localparam int STAGES = 5;
    localparam int FBLEN  = 17;
`ifdef FPF_DEC_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    fpf_decoder_25_if bus();

    fpf_decoder_25 #(.STAGES(STAGES)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int fibw [1:25];

    // ---------------- reference model ----------------
    function automatic int decode_ref(input logic [24:0] c);
        int s;
        s = 0;
        for (int k = 0; k < 25; k++) if (c[k]) s += fibw[k+1];
        return s;
    endfunction

    function automatic logic [FBLEN-1:0] data_ref(input logic [24:0] c);
        return FBLEN'(decode_ref(c));
    endfunction

    function automatic logic err_ref(input logic [24:0] c);
        logic e;
        logic [2:0] t;
        e = 1'b0;
        for (int k = 0; k < 23; k++) begin
            t = c[k +: 3];
            if (t == 3'b010 || t == 3'b101) e = 1'b1;
        end
        if (decode_ref(c) >= (1 << FBLEN)) e = 1'b1;
        return e & CHECK;
    endfunction

    // Greedy Fibonacci representation using weights Fib(2)..Fib(25).
    function automatic logic [24:0] encode_ref(input int n);
        logic [24:0] c;
        int r;
        c = '0;
        r = n;
        for (int k = 25; k >= 2; k--) begin
            if (fibw[k] <= r) begin
                c[k-1] = 1'b1;
                r -= fibw[k];
            end
        end
        return c;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.codein    = 25'($urandom);
        bus.out_ready = 1'b1;
        repeat (3) next_cycle();
        @(negedge clock);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.dataout !== '0) begin bad++; $display("FAIL reset_dataout: got %0h want 0", bus.dataout); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        next_cycle();
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid); end
        next_cycle();
    endtask

    task automatic test_single();
        logic [FBLEN-1:0] want;
        want = FBLEN'(fibw[1] + fibw[2]);
        bus.codein    = 25'h0000003;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        // cyc = rising edges since the word was first presented
        for (int cyc = 0; cyc <= STAGES + 1; cyc++) begin
            @(negedge clock);
            total++;
            if (bus.out_valid !== (cyc == STAGES)) begin
                bad++; $display("FAIL single_valid cyc%0d: got %b want %b", cyc, bus.out_valid, (cyc == STAGES));
            end
            if (cyc == STAGES) begin
                total++; if (bus.dataout !== want) begin bad++; $display("FAIL single_data: got %0d want %0d", bus.dataout, want); end
                total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", bus.err); end
            end
            next_cycle();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit gap  = 1'b0;
        bus.out_ready = 1'b1;
        while (got < 100 && cyc < 300) begin
            bus.in_valid = (sent < 100);
            bus.codein   = encode_ref(sent);
            @(negedge clock);
            if (bus.out_valid) begin
                total++;
                if (bus.dataout !== FBLEN'(got)) begin bad++; $display("FAIL stream_data #%0d: got %0d want %0d", got, bus.dataout, got); end
                got++;
            end else if (got > 0) begin
                gap = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            next_cycle();
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++; if (got !== 100) begin bad++; $display("FAIL stream_count: got %0d want 100", got); end
        total++; if (gap !== 1'b0) begin bad++; $display("FAIL stream_gap: got %b want 0", gap); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic [FBLEN-1:0] held = '0;
        while (got < 30 && cyc < 200) begin
            bus.out_ready = !(cyc >= 12 && cyc < 19);
            bus.in_valid  = (sent < 30);
            bus.codein    = encode_ref(1000 + sent);
            @(negedge clock);
            if (!bus.out_ready) begin
                total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, bus.in_ready); end
                total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc%0d: got %b want 1", cyc, bus.out_valid); end
                if (cyc > 12) begin
                    total++; if (bus.dataout !== held) begin bad++; $display("FAIL bp_stable cyc%0d: got %0d want %0d", cyc, bus.dataout, held); end
                end
                held = bus.dataout;
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (bus.dataout !== FBLEN'(1000 + got)) begin bad++; $display("FAIL bp_data #%0d: got %0d want %0d", got, bus.dataout, 1000 + got); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            next_cycle();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++; if (got !== 30) begin bad++; $display("FAIL bp_count: got %0d want 30", got); end
    endtask

    task automatic test_patterns();
        logic [24:0] codes [6];
        int n;
        codes = '{25'h0000005, 25'h0000007, 25'h1FFFFFF, 25'h0000000, 25'h0000012, 25'h0AAAAAA};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.codein   = codes[i];
            bus.in_valid = 1'b1;
            next_cycle();
            bus.in_valid = 1'b0;
            n = 0;
            for (n = 0; n < 20; n++) begin
                @(negedge clock);
                if (bus.out_valid) break;
                next_cycle();
            end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pat_timeout %0h: got %b want 1", codes[i], bus.out_valid); end
            total++; if (n !== STAGES - 1) begin bad++; $display("FAIL pat_latency %0h: got %0d want %0d", codes[i], n, STAGES - 1); end
            total++; if (bus.dataout !== data_ref(codes[i])) begin bad++; $display("FAIL pat_data %0h: got %0d want %0d", codes[i], bus.dataout, data_ref(codes[i])); end
            total++; if (bus.err !== err_ref(codes[i])) begin bad++; $display("FAIL pat_err %0h: got %b want %b", codes[i], bus.err, err_ref(codes[i])); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        int n;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.codein   = encode_ref(7 + i);
            bus.in_valid = 1'b1;
            next_cycle();
        end
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b0) spurious++;
            next_cycle();
        end
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b0) spurious++;
            next_cycle();
        end
        total++; if (spurious !== 0) begin bad++; $display("FAIL midreset_flushed: got %0d outputs want 0", spurious); end
        bus.codein   = encode_ref(42);
        bus.in_valid = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clock);
            if (bus.out_valid) break;
            next_cycle();
        end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midreset_timeout: got %b want 1", bus.out_valid); end
        total++; if (bus.dataout !== FBLEN'(42)) begin bad++; $display("FAIL midreset_data: got %0d want 42", bus.dataout); end
        next_cycle();
    endtask

    // Random traffic checked cycle by cycle against a STAGES-deep delay line
    // that only moves when the consumer is not holding the output.
    task automatic test_random();
        bit          mv [STAGES];
        logic [24:0] mc [STAGES];
        bit          stall_m;
        for (int k = 0; k < STAGES; k++) begin mv[k] = 1'b0; mc[k] = '0; end
        repeat (400) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.codein    = ($urandom_range(0, 1) == 0) ? encode_ref(int'($urandom_range(0, 121392))) : 25'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            stall_m = mv[STAGES-1] && !bus.out_ready;
            total++; if (bus.out_valid !== mv[STAGES-1]) begin bad++; $display("FAIL rnd_valid: got %b want %b", bus.out_valid, mv[STAGES-1]); end
            total++; if (bus.in_ready !== !stall_m) begin bad++; $display("FAIL rnd_in_ready: got %b want %b", bus.in_ready, !stall_m); end
            if (mv[STAGES-1]) begin
                total++; if (bus.dataout !== data_ref(mc[STAGES-1])) begin bad++; $display("FAIL rnd_data %0h: got %0d want %0d", mc[STAGES-1], bus.dataout, data_ref(mc[STAGES-1])); end
                total++; if (bus.err !== err_ref(mc[STAGES-1])) begin bad++; $display("FAIL rnd_err %0h: got %b want %b", mc[STAGES-1], bus.err, err_ref(mc[STAGES-1])); end
            end else begin
                total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rnd_err_idle: got %b want 0", bus.err); end
            end
            if (!stall_m) begin
                for (int k = STAGES - 1; k > 0; k--) begin mv[k] = mv[k-1]; mc[k] = mc[k-1]; end
                mv[0] = bus.in_valid;
                mc[0] = bus.codein;
            end
            next_cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        fibw[1] = 1;
        fibw[2] = 1;
        for (int k = 3; k <= 25; k++) fibw[k] = fibw[k-1] + fibw[k-2];
        bus.in_valid  = 1'b0;
        bus.codein    = '0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;
        #1;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_patterns();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
